// File: rtl/wb_pipe_if.sv
// wb_pipe_if: write-back bundle bus (valid/ready, stall, flush, occupancy); master drives upstream/control side, slave is the stage
interface wb_pipe_if #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic en_reg;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_wn;
  logic out_valid;
  logic out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_wn;
  logic [1:0] occ;
  modport master (
    output en_reg, flush, in_valid, in_ctrl, in_data, in_wn, out_ready,
    input in_ready, out_valid, out_ctrl, out_data, out_wn, occ
  );
  modport slave (
    input en_reg, flush, in_valid, in_ctrl, in_data, in_wn, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_wn, occ
  );
endinterface

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: elastic 2-entry skid-buffered write-back stage; ports clk, rst, bus (wb_pipe_if.slave), stall_cnt only with WB_PIPE_STAGE_PERF_EN
module wb_pipe_stage #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst,
`ifdef WB_PIPE_STAGE_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  wb_pipe_if.slave bus
);
  localparam int W = CTRL_W + DATA_W + ADDR_W;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [W-1:0] head_q, head_d, skid_q, skid_d, in_bundle;
  logic push, pop;
  assign in_bundle = {bus.in_ctrl, bus.in_data, bus.in_wn};
  assign bus.in_ready = ~rst & bus.en_reg & ~bus.flush & (state_q != FULL);
  assign bus.out_valid = ~rst & bus.en_reg & (state_q != EMPTY);
  assign push = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  assign bus.out_ctrl = state_q == EMPTY ? '0 : head_q[W-1 -: CTRL_W];
  assign bus.out_data = head_q[ADDR_W +: DATA_W];
  assign bus.out_wn = head_q[ADDR_W-1:0];
  assign bus.occ = state_q;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    skid_d = skid_q;
    if (bus.flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: begin
          state_d = push ? ONE : EMPTY;
          head_d = push ? in_bundle : head_q;
        end
        ONE: begin
          state_d = push & ~pop ? FULL : pop & ~push ? EMPTY : ONE;
          head_d = push & pop ? in_bundle : head_q;
          skid_d = push & ~pop ? in_bundle : skid_q;
        end
        FULL: begin
          state_d = pop ? ONE : FULL;
          head_d = pop ? skid_q : head_q;
        end
        default: state_d = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
`ifdef WB_PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  assign stall_cnt_d = bus.out_valid & ~bus.out_ready & ~&stall_cnt_q ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign stall_cnt = stall_cnt_q;
  always_ff @(posedge clk) stall_cnt_q <= rst ? '0 : stall_cnt_d;
`endif
endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb_wb_pipe_stage: directed self-checking bench for wb_pipe_stage
module tb_wb_pipe_stage;
  logic clk = 0;
  logic rst;
  int total = 0;
  int bad = 0;
  wb_pipe_if bus ();
`ifdef WB_PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  wb_pipe_stage dut (.clk(clk), .rst(rst), .stall_cnt(stall_cnt), .bus(bus));
`else
  wb_pipe_stage dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [63:0] d);
    bus.in_valid = v;
    bus.in_data = d;
  endtask
  initial begin
    rst = 1;
    bus.en_reg = 1;
    bus.flush = 0;
    bus.out_ready = 0;
    bus.in_ctrl = 2'b11;
    bus.in_wn = 5'd7;
    drive(1, 64'h99);
    step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_occ", bus.occ, 0);
    step();
    chk("rst_in_ready2", bus.in_ready, 0);
    chk("rst_occ2", bus.occ, 0);
    chk("rst_ctrl", bus.out_ctrl, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_wn", bus.out_wn, 0);
    rst = 0;
    drive(0, 0);
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    bus.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 64'h11 + 64'(i));
      step();
      chk("str_valid", bus.out_valid, 1);
      chk("str_data", bus.out_data, 64'h11 + 64'(i));
      chk("str_ctrl", bus.out_ctrl, 3);
      chk("str_wn", bus.out_wn, 7);
      chk("str_occ", bus.occ, 1);
      chk("str_in_ready", bus.in_ready, 1);
    end
    drive(0, 0);
    step();
    chk("str_drain_occ", bus.occ, 0);
    chk("str_bubble_ctrl", bus.out_ctrl, 0);
    chk("str_hold_data", bus.out_data, 64'h15);
    bus.out_ready = 0;
    drive(1, 64'hA);
    step();
    drive(1, 64'hB);
    step();
    chk("bp_occ", bus.occ, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_head", bus.out_data, 64'hA);
    drive(1, 64'hC);
    bus.out_ready = 1;
    step();
    chk("bp_pop_a_occ", bus.occ, 1);
    chk("bp_head_b", bus.out_data, 64'hB);
    step();
    chk("bp_head_c", bus.out_data, 64'hC);
    chk("bp_occ_c", bus.occ, 1);
    drive(0, 0);
    step();
    chk("bp_empty", bus.occ, 0);
    bus.out_ready = 0;
    drive(1, 64'hA);
    step();
    drive(1, 64'hB);
    step();
    chk("fl_pre_occ", bus.occ, 2);
    bus.flush = 1;
    drive(1, 64'hC);
    #1;
    chk("fl_in_ready", bus.in_ready, 0);
    step();
    bus.flush = 0;
    drive(0, 0);
    #1;
    chk("fl_occ", bus.occ, 0);
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_ctrl", bus.out_ctrl, 0);
    step();
    chk("fl_no_c", bus.out_data, 64'hA);
    drive(1, 64'hA);
    step();
    bus.en_reg = 0;
    bus.out_ready = 1;
    drive(1, 64'hD);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_valid", bus.out_valid, 0);
      chk("st_in_ready", bus.in_ready, 0);
      step();
      chk("st_head", bus.out_data, 64'hA);
      chk("st_occ", bus.occ, 1);
    end
    bus.en_reg = 1;
    #1;
    chk("st_rel_valid", bus.out_valid, 1);
    chk("st_rel_head", bus.out_data, 64'hA);
    step();
    chk("st_new_head", bus.out_data, 64'hD);
    drive(0, 0);
    step();
    chk("st_drain", bus.occ, 0);
    bus.out_ready = 0;
    drive(1, 64'hE);
    step();
    rst = 1;
    drive(0, 0);
    step();
    rst = 0;
    chk("mid_rst_occ", bus.occ, 0);
    chk("mid_rst_data", bus.out_data, 0);
`ifdef WB_PIPE_STAGE_PERF_EN
    chk("pf_rst", stall_cnt, 0);
    drive(1, 64'h5);
    step();
    drive(0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("pf_cnt5", stall_cnt, 5);
    bus.out_ready = 1;
    bus.flush = 1;
    step();
    bus.flush = 0;
    chk("pf_flush_keep", stall_cnt, 5);
    rst = 1;
    step();
    rst = 0;
    chk("pf_rst_clr", stall_cnt, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
